// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the PC, issues one-cycle-latency memory reads,
// buffers {pc, instr} pairs in a 2-entry FIFO toward decode and handles redirects.
module instruction_fetch #(
    parameter int                 DWIDTH   = 32,
    parameter logic [DWIDTH-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DWIDTH-1:0] memAddressOut,
    output logic              memEnable,
    input  logic [DWIDTH-1:0] memInstructionIn,
    input  logic              redirectValid,
    input  logic [DWIDTH-1:0] redirectPc,
    output logic              instrValid,
    input  logic              instrReady,
    output logic [DWIDTH-1:0] instrOut,
    output logic [DWIDTH-1:0] pcOut,
    output logic              misalignFault
);

    localparam int DEPTH = 2;

    logic [DWIDTH-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [DWIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic              squash_q, squash_d;
    logic              misalign_q, misalign_d;
    logic [1:0]        count_q, count_d;
    logic [DWIDTH-1:0] fifo_instr_q [DEPTH];
    logic [DWIDTH-1:0] fifo_instr_d [DEPTH];
    logic [DWIDTH-1:0] fifo_pc_q    [DEPTH];
    logic [DWIDTH-1:0] fifo_pc_d    [DEPTH];

    logic              deq;
    logic              enq;
    logic              mem_en;
    logic [2:0]        occupancy;

    // Occupancy after this cycle's dequeue must leave room for the fetch being issued.
    always_comb begin
        deq       = (count_q != 2'd0) & instrReady;
        enq       = inflight_q & ~squash_q & ~redirectValid;
        occupancy = 3'(count_q) + 3'(inflight_q) - 3'(deq);
        mem_en    = reset & ~redirectValid & (occupancy <= 3'd1);
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = mem_en;
        inflight_pc_d = inflight_pc_q;
        squash_d      = redirectValid & inflight_q;
        misalign_d    = redirectValid & (redirectPc[1:0] != 2'b00);

        if (redirectValid) begin
            pc_d = {redirectPc[DWIDTH-1:2], 2'b00};
        end else if (mem_en) begin
            pc_d = pc_q + DWIDTH'(4);
        end
        if (mem_en) begin
            inflight_pc_d = pc_q;
        end
    end

    // FIFO: slot 0 is the head; a redirect flushes everything, including a same-cycle dequeue.
    always_comb begin
        count_d      = count_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;

        if (redirectValid) begin
            count_d = 2'd0;
        end else begin
            case ({enq, deq})
                2'b10: begin
                    fifo_instr_d[count_q[0]] = memInstructionIn;
                    fifo_pc_d[count_q[0]]    = inflight_pc_q;
                    count_d                  = count_q + 2'd1;
                end
                2'b01: begin
                    fifo_instr_d[0] = fifo_instr_q[1];
                    fifo_pc_d[0]    = fifo_pc_q[1];
                    count_d         = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        fifo_instr_d[0] = memInstructionIn;
                        fifo_pc_d[0]    = inflight_pc_q;
                    end else begin
                        fifo_instr_d[0] = fifo_instr_q[1];
                        fifo_pc_d[0]    = fifo_pc_q[1];
                        fifo_instr_d[1] = memInstructionIn;
                        fifo_pc_d[1]    = inflight_pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            squash_q      <= 1'b0;
            misalign_q    <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            squash_q      <= squash_d;
            misalign_q    <= misalign_d;
            count_q       <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                fifo_instr_q[gi] <= '0;
                fifo_pc_q[gi]    <= '0;
            end else begin
                fifo_instr_q[gi] <= fifo_instr_d[gi];
                fifo_pc_q[gi]    <= fifo_pc_d[gi];
            end
        end
    end

    assign memAddressOut = pc_q;
    assign memEnable     = mem_en;
    assign instrValid    = (count_q != 2'd0);
    assign instrOut      = fifo_instr_q[0];
    assign pcOut         = fifo_pc_q[0];
    assign misalignFault = misalign_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: synchronous memory model, accepted-stream monitor,
// and scenario tasks that compare DUT behaviour against the expected fetch stream.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk;
    logic        reset;
    logic [31:0] memAddressOut;
    logic        memEnable;
    logic [31:0] memInstructionIn;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instrOut;
    logic [31:0] pcOut;
    logic        misalignFault;

    int checks   = 0;
    int failures = 0;
    int n_issued   = 0;
    int n_accepted = 0;

    typedef struct packed {
        logic        mk;
        logic [31:0] pc;
        logic [31:0] ins;
    } ev_t;
    ev_t evq[$];

    instruction_fetch #(.DWIDTH(32), .RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .reset            (reset),
        .memAddressOut    (memAddressOut),
        .memEnable        (memEnable),
        .memInstructionIn (memInstructionIn),
        .redirectValid    (redirectValid),
        .redirectPc       (redirectPc),
        .instrValid       (instrValid),
        .instrReady       (instrReady),
        .instrOut         (instrOut),
        .pcOut            (pcOut),
        .misalignFault    (misalignFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Synchronous instruction memory: data for the enabled address appears next cycle.
    always @(posedge clk) begin
        if (memEnable) memInstructionIn <= mem_word(memAddressOut);
    end

    // Records what decode accepts; a redirect cycle records a marker with the aligned target.
    always @(negedge clk) begin
        if (reset) begin
            if (memEnable) n_issued++;
            if (redirectValid) begin
                evq.push_back({1'b1, redirectPc & ~32'h3, 32'h0});
            end else if (instrValid && instrReady) begin
                evq.push_back({1'b0, pcOut, instrOut});
                n_accepted++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; instrReady = 1'b0; redirectValid = 1'b0; redirectPc = '0;
        memInstructionIn = '0;
        repeat (2) @(negedge clk);
        checks++; if (memEnable !== 1'b0) begin failures++; $display("FAIL reset_memEnable got=%b exp=0", memEnable); end
        checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL reset_instrValid got=%b exp=0", instrValid); end
        checks++; if (instrOut !== 32'h0) begin failures++; $display("FAIL reset_instrOut got=%h exp=0", instrOut); end
        checks++; if (pcOut !== 32'h0) begin failures++; $display("FAIL reset_pcOut got=%h exp=0", pcOut); end
        checks++; if (misalignFault !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalignFault); end
        checks++; if (memAddressOut !== RST_PC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", memAddressOut, RST_PC); end
        evq.delete(); n_issued = 0; n_accepted = 0;
        tick();
        reset = 1'b1; instrReady = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_startup();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (memEnable !== 1'b1 || memAddressOut !== RST_PC + 32'(4 * k)) begin
                failures++; $display("FAIL startup_issue k=%0d got=%b/%h exp=1/%h", k, memEnable, memAddressOut, RST_PC + 32'(4 * k));
            end
            if (k < 2) begin
                checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL startup_early_valid k=%0d got=%b exp=0", k, instrValid); end
            end else begin
                checks++; if (instrValid !== 1'b1 || pcOut !== RST_PC + 32'(4 * (k - 2)) || instrOut !== mem_word(RST_PC + 32'(4 * (k - 2)))) begin
                    failures++; $display("FAIL startup_head k=%0d got=%b/%h/%h exp=1/%h/%h", k, instrValid, pcOut, instrOut,
                                         RST_PC + 32'(4 * (k - 2)), mem_word(RST_PC + 32'(4 * (k - 2))));
                end
            end
        end
        $display("test_startup done");
    endtask

    task automatic test_stall();
        logic [31:0] held_pc, held_ins, exp_pc;
        int ndata;
        tick();
        instrReady = 1'b0;
        held_pc = '0; held_ins = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (instrValid !== 1'b1) begin failures++; $display("FAIL stall_valid i=%0d got=%b exp=1", i, instrValid); end
            if (i == 0) begin
                held_pc = pcOut; held_ins = instrOut;
            end else begin
                checks++; if (pcOut !== held_pc || instrOut !== held_ins) begin
                    failures++; $display("FAIL stall_hold i=%0d got=%h/%h exp=%h/%h", i, pcOut, instrOut, held_pc, held_ins);
                end
            end
            if (i == 4) begin
                checks++; if (memEnable !== 1'b0) begin failures++; $display("FAIL stall_memEnable got=%b exp=0", memEnable); end
            end
        end
        tick();
        checks++; if (n_issued - n_accepted !== 2) begin
            failures++; $display("FAIL stall_outstanding got=%0d exp=2", n_issued - n_accepted);
        end
        instrReady = 1'b1;
        repeat (8) @(negedge clk);
        tick();
        exp_pc = RST_PC; ndata = 0;
        foreach (evq[i]) begin
            if (evq[i].mk) begin
                exp_pc = evq[i].pc;
            end else begin
                ndata++;
                checks++; if (evq[i].pc !== exp_pc || evq[i].ins !== mem_word(exp_pc)) begin
                    failures++; $display("FAIL stall_stream idx=%0d got=%h/%h exp=%h/%h", i, evq[i].pc, evq[i].ins, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4;
            end
        end
        checks++; if (ndata < 10) begin failures++; $display("FAIL stall_count got=%0d exp>=10", ndata); end
        $display("test_stall done: %0d instructions delivered", ndata);
    endtask

    task automatic test_redirect(input logic [31:0] target, input string tag);
        logic [31:0] al;
        al = target & ~32'h3;
        redirectValid = 1'b1; redirectPc = target;
        @(negedge clk);
        checks++; if (memEnable !== 1'b0) begin failures++; $display("FAIL %s_R_memEnable got=%b exp=0", tag, memEnable); end
        checks++; if (misalignFault !== 1'b0) begin failures++; $display("FAIL %s_R_misalign got=%b exp=0", tag, misalignFault); end
        tick();
        redirectValid = 1'b0;
        @(negedge clk);
        checks++; if (memEnable !== 1'b1 || memAddressOut !== al) begin
            failures++; $display("FAIL %s_R1_issue got=%b/%h exp=1/%h", tag, memEnable, memAddressOut, al);
        end
        checks++; if (misalignFault !== (target[1:0] != 2'b00)) begin
            failures++; $display("FAIL %s_R1_misalign got=%b exp=%b", tag, misalignFault, target[1:0] != 2'b00);
        end
        checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL %s_R1_valid got=%b exp=0", tag, instrValid); end
        @(negedge clk);
        checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL %s_R2_valid got=%b exp=0", tag, instrValid); end
        checks++; if (misalignFault !== 1'b0) begin failures++; $display("FAIL %s_R2_misalign got=%b exp=0", tag, misalignFault); end
        @(negedge clk);
        checks++; if (instrValid !== 1'b1 || pcOut !== al || instrOut !== mem_word(al)) begin
            failures++; $display("FAIL %s_R3_head got=%b/%h/%h exp=1/%h/%h", tag, instrValid, pcOut, instrOut, al, mem_word(al));
        end
        @(negedge clk);
        checks++; if (instrValid !== 1'b1 || pcOut !== al + 32'd4) begin
            failures++; $display("FAIL %s_R4_head got=%b/%h exp=1/%h", tag, instrValid, pcOut, al + 32'd4);
        end
        tick();
        $display("test_redirect %s done: target %h", tag, target);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        int ndata;
        evq.delete();
        redirectValid = 1'b1; redirectPc = 32'h100;
        @(negedge clk);
        checks++; if (memEnable !== 1'b0) begin failures++; $display("FAIL b2b_R_memEnable got=%b exp=0", memEnable); end
        tick();
        redirectPc = 32'h200;
        @(negedge clk);
        checks++; if (memEnable !== 1'b0) begin failures++; $display("FAIL b2b_R1_memEnable got=%b exp=0", memEnable); end
        tick();
        redirectValid = 1'b0;
        @(negedge clk);
        checks++; if (memEnable !== 1'b1 || memAddressOut !== 32'h200) begin
            failures++; $display("FAIL b2b_issue got=%b/%h exp=1/00000200", memEnable, memAddressOut);
        end
        @(negedge clk);
        checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL b2b_stale got=%b exp=0", instrValid); end
        @(negedge clk);
        checks++; if (instrValid !== 1'b1 || pcOut !== 32'h200) begin
            failures++; $display("FAIL b2b_head got=%b/%h exp=1/00000200", instrValid, pcOut);
        end
        repeat (6) @(negedge clk);
        tick();
        exp_pc = 32'hFFFF_FFFF; ndata = 0;
        foreach (evq[i]) begin
            if (evq[i].mk) begin
                exp_pc = evq[i].pc;
            end else begin
                ndata++;
                checks++; if (evq[i].pc !== exp_pc || evq[i].ins !== mem_word(exp_pc) || exp_pc < 32'h200) begin
                    failures++; $display("FAIL b2b_stream idx=%0d got=%h/%h exp=%h/%h", i, evq[i].pc, evq[i].ins, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4;
            end
        end
        checks++; if (ndata < 6) begin failures++; $display("FAIL b2b_count got=%0d exp>=6", ndata); end
        $display("test_back_to_back done: %0d instructions delivered", ndata);
    endtask

    task automatic test_reset_midop();
        instrReady = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (instrValid !== 1'b1) begin failures++; $display("FAIL rst_mid_prefill got=%b exp=1", instrValid); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (instrValid !== 1'b0 || memEnable !== 1'b0) begin
            failures++; $display("FAIL rst_mid_async got=%b/%b exp=0/0", instrValid, memEnable);
        end
        checks++; if (pcOut !== 32'h0 || instrOut !== 32'h0 || memAddressOut !== RST_PC) begin
            failures++; $display("FAIL rst_mid_clear got=%h/%h/%h exp=0/0/%h", pcOut, instrOut, memAddressOut, RST_PC);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1; instrReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 2) begin
                checks++; if (instrValid !== 1'b0 || memAddressOut !== RST_PC + 32'(4 * k)) begin
                    failures++; $display("FAIL rst_mid_restart k=%0d got=%b/%h exp=0/%h", k, instrValid, memAddressOut, RST_PC + 32'(4 * k));
                end
            end else begin
                checks++; if (instrValid !== 1'b1 || pcOut !== RST_PC + 32'(4 * (k - 2)) || instrOut !== mem_word(RST_PC + 32'(4 * (k - 2)))) begin
                    failures++; $display("FAIL rst_mid_head k=%0d got=%b/%h exp=1/%h", k, instrValid, pcOut, RST_PC + 32'(4 * (k - 2)));
                end
            end
        end
        tick();
        $display("test_reset_midop done");
    endtask

    task automatic test_random();
        logic        prev_mis, exp_mis;
        logic [31:0] exp_pc;
        int ndata;
        prev_mis = 1'b0;
        evq.delete();
        for (int c = 0; c < 400; c++) begin
            instrReady    = ($urandom_range(0, 9) < 7);
            redirectValid = (c == 0) || ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) redirectPc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else                           redirectPc = $urandom & 32'h0000_0FFF;
            exp_mis  = prev_mis;
            prev_mis = redirectValid & (redirectPc[1:0] != 2'b00);
            @(negedge clk);
            checks++; if (misalignFault !== exp_mis) begin
                failures++; $display("FAIL rand_misalign c=%0d got=%b exp=%b", c, misalignFault, exp_mis);
            end
            if (redirectValid || memEnable) begin
                checks++; if ((redirectValid && memEnable) || memAddressOut[1:0] !== 2'b00) begin
                    failures++; $display("FAIL rand_issue c=%0d got=%b/%h exp=%b/aligned", c, memEnable, memAddressOut, !redirectValid);
                end
            end
            tick();
        end
        redirectValid = 1'b0; instrReady = 1'b1;
        repeat (6) @(negedge clk);
        tick();
        exp_pc = '0; ndata = 0;
        foreach (evq[i]) begin
            if (evq[i].mk) begin
                exp_pc = evq[i].pc;
            end else begin
                ndata++;
                checks++; if (evq[i].pc !== exp_pc || evq[i].ins !== mem_word(exp_pc)) begin
                    failures++; $display("FAIL rand_stream idx=%0d got=%h/%h exp=%h/%h", i, evq[i].pc, evq[i].ins, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4;
            end
        end
        checks++; if (ndata < 50) begin failures++; $display("FAIL rand_count got=%0d exp>=50", ndata); end
        $display("test_random done: %0d instructions delivered", ndata);
    endtask

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_redirect(32'h40, "redirect");
        test_redirect(32'h43, "misalign");
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
